// File: rtl/wrr_hold_arbiter_pkg.sv
// Shared types and helpers for the hold-style round-robin arbiters.
package arb_pkg;

    // Default requester count and the matching index width
    localparam int ARB_N = 4;
    localparam int IDX_W = (ARB_N > 1) ? $clog2(ARB_N) : 1;

    // Widest requester vector the onehot helper can produce
    localparam int MAX_N = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // One-hot vector with bit idx set; callers size-cast to their width
    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
        logic [MAX_N-1:0] v;
        v = '0;
        v[idx[4:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotate-priority picker: first set bit of eligible at or after start, wrapping.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] winner
);

    // Scan N positions starting at start; the first hit wins
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(start) + k) % N;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/wrr_hold_arbiter.sv
// Weighted round-robin arbiter where the winner holds ownership until done,
// request drop or hold timeout. Credits reload from weight only when no
// requesting line has credit left.
//
// state | meaning
// IDLE  | no owner; reload credits or pick the next eligible requester
// OWNED | grant held; watch done, owner request and hold counter
module wrr_hold_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int WW       = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N-1:0]                      req,
    input  logic                              done,
    input  logic [N*WW-1:0]                   weight,
    output logic [N-1:0]                      grant,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx,
    output logic                              busy,
    output logic                              timeout
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

    arb_state_t    state;
    logic [WW-1:0] credit [N];
    logic [IW-1:0] last;
    logic [HW-1:0] hold_cnt;

    logic [N-1:0]  eligible;
    logic [IW-1:0] start;
    logic          found;
    logic [IW-1:0] pick_idx;
    logic          rel_done;
    logic          rel_req;
    logic          rel_hold;

    // Requesters that still have budget this round
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N; i++) begin
            eligible[i] = req[i] && (credit[i] != '0);
        end
    end

    // Search begins one past the previous winner, wrapping at N-1
    always_comb begin
        start = (last == IW'(N - 1)) ? '0 : last + 1'b1;
    end

    rr_picker #(
        .N  (N),
        .IW (IW)
    ) u_picker (
        .eligible (eligible),
        .start    (start),
        .found    (found),
        .winner   (pick_idx)
    );

    // Release causes while owned; done outranks the timeout
    always_comb begin
        rel_done = done;
        rel_req  = !req[grant_idx];
        rel_hold = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD));
    end

    // Arbitration FSM with registered grant, status and credit bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
            last      <= IW'(N - 1);
            hold_cnt  <= '0;
            for (int i = 0; i < N; i++) begin
                credit[i] <= '0;
            end
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        if (found) begin
                            grant            <= N'(onehot(int'(pick_idx)));
                            grant_idx        <= pick_idx;
                            busy             <= 1'b1;
                            credit[pick_idx] <= credit[pick_idx] - 1'b1;
                            last             <= pick_idx;
                            hold_cnt         <= HW'(1);
                            state            <= OWNED;
                        end else begin
                            // Nobody requesting has budget: start a new round
                            for (int i = 0; i < N; i++) begin
                                credit[i] <= weight[i*WW +: WW];
                            end
                        end
                    end
                end
                OWNED: begin
                    if (rel_done || rel_req || rel_hold) begin
                        grant   <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                        timeout <= rel_hold && !rel_done && !rel_req;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wrr_hold_arbiter.sv
// Directed bench for wrr_hold_arbiter (N=4, WW=4, MAX_HOLD=8).
module tb_wrr_hold_arbiter;

    localparam int N        = 4;
    localparam int WW       = 4;
    localparam int MAX_HOLD = 8;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req;
    logic          done;
    logic [N*WW-1:0] weight;
    logic [N-1:0]  grant;
    logic [1:0]    grant_idx;
    logic          busy;
    logic          timeout;

    int n_cmp;
    int n_bad;

    wrr_hold_arbiter #(
        .N        (N),
        .WW       (WW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .weight    (weight),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = '0;
        done  = 1'b0;
        repeat (2) tick();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_idx", 32'(grant_idx), 0);
    endtask

    // Waits for busy; checks owner index, one-hot grant and cycles waited
    task automatic wait_grant(input string tag, input int exp_idx, input int exp_wait);
        int n;
        n = 0;
        while (!busy && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_wait"}, 32'(n), 32'(exp_wait));
        chk({tag, "_idx"}, 32'(grant_idx), 32'(exp_idx));
        chk({tag, "_grant"}, 32'(grant), 32'(1 << exp_idx));
    endtask

    // Holds the grant for hold cycles, releasing with a done pulse
    task automatic release_done(input string tag, input int hold);
        repeat (hold - 1) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk({tag, "_rel_grant"}, 32'(grant), 0);
        chk({tag, "_rel_to"}, 32'(timeout), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        int cnt;
        n_cmp  = 0;
        n_bad  = 0;
        reset  = 1'b1;
        req    = '0;
        done   = 1'b0;
        weight = '0;

        // 1: all weights 1, everyone requesting
        apply_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        req    = 4'b1111;
        reset  = 1'b0;
        wait_grant("t1_a0", 0, 2);
        release_done("t1_a0", 2);
        wait_grant("t1_a1", 1, 1);
        release_done("t1_a1", 2);
        wait_grant("t1_a2", 2, 1);
        release_done("t1_a2", 2);
        wait_grant("t1_a3", 3, 1);
        release_done("t1_a3", 2);
        wait_grant("t1_b0", 0, 2);
        release_done("t1_b0", 2);
        wait_grant("t1_b1", 1, 1);
        release_done("t1_b1", 2);
        wait_grant("t1_b2", 2, 1);
        release_done("t1_b2", 2);
        wait_grant("t1_b3", 3, 1);
        release_done("t1_b3", 2);

        // 2: w0=3, w1=1; rotation pointer persists across the reload, so
        //    after the round 0,1,0,0 the next round starts from 1
        apply_reset();
        weight = {4'd0, 4'd0, 4'd1, 4'd3};
        req    = 4'b0011;
        reset  = 1'b0;
        wait_grant("t2_a", 0, 2);
        release_done("t2_a", 2);
        wait_grant("t2_b", 1, 1);
        release_done("t2_b", 2);
        wait_grant("t2_c", 0, 1);
        release_done("t2_c", 2);
        wait_grant("t2_d", 0, 1);
        release_done("t2_d", 2);
        wait_grant("t2_e", 1, 2);
        release_done("t2_e", 2);
        wait_grant("t2_f", 0, 1);
        release_done("t2_f", 2);
        wait_grant("t2_g", 0, 1);
        release_done("t2_g", 2);
        wait_grant("t2_h", 0, 1);
        release_done("t2_h", 2);

        // 3: hold timeout with no done
        apply_reset();
        weight = {4'd0, 4'd0, 4'd0, 4'd2};
        req    = 4'b0001;
        reset  = 1'b0;
        wait_grant("t3_a", 0, 2);
        cnt = 1;
        chk("t3_to_early", 32'(timeout), 0);
        while (busy && cnt < 30) begin
            tick();
            if (busy) begin
                cnt++;
                chk("t3_to_held", 32'(timeout), 0);
            end
        end
        chk("t3_hold_len", 32'(cnt), 32'(MAX_HOLD));
        chk("t3_to_pulse", 32'(timeout), 1);
        tick();
        chk("t3_to_clear", 32'(timeout), 0);
        chk("t3_regrant", 32'(grant), 1);
        req = '0;
        tick();
        chk("t3_reqdrop_grant", 32'(grant), 0);
        chk("t3_reqdrop_to", 32'(timeout), 0);

        // 4: owner drops request mid-hold, next requester takes over
        apply_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        req    = 4'b1100;
        reset  = 1'b0;
        wait_grant("t4_a", 2, 2);
        repeat (2) tick();
        req = 4'b1000;
        tick();
        chk("t4_drop_grant", 32'(grant), 0);
        chk("t4_drop_to", 32'(timeout), 0);
        wait_grant("t4_b", 3, 1);

        // 5: asynchronous reset while owned
        apply_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        req    = 4'b1111;
        reset  = 1'b0;
        wait_grant("t5_a", 0, 2);
        release_done("t5_a", 2);
        wait_grant("t5_b", 1, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_grant", 32'(grant), 0);
        chk("t5_async_busy", 32'(busy), 0);
        chk("t5_async_to", 32'(timeout), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_grant("t5_c", 0, 2);
        release_done("t5_c", 2);

        // 6: zero weight never wins; arbiter keeps reloading without lockup
        apply_reset();
        weight = {4'd0, 4'd0, 4'd0, 4'd2};
        req    = 4'b0010;
        reset  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t6_busy", 32'(busy), 0);
            chk("t6_grant", 32'(grant), 0);
        end
        req = 4'b0011;
        wait_grant("t6_w0", 0, 1);
        release_done("t6_w0", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
